// File: rtl/ram_bist_master_pkg.sv
// ---------------------------------------------------------------------------
// ram_bist_master_pkg
// Shared definitions for the RAM BIST master.
//   * state_t and the FSM state encodings (IDLE, WRITE, TURN, READ, DRAIN, DONE)
//   * pat(): the test pattern for word offset k, seed + k, wrapping modulo the
//     caller's data width once the result is truncated.
// ---------------------------------------------------------------------------
package ram_bist_master_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WRITE = 3'd1;
    localparam state_t ST_TURN  = 3'd2;
    localparam state_t ST_READ  = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // The callers truncate the sum to their data width.
    // That truncation performs the modulo-2^DW wrap.
    function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] k);
        return seed + k;
    endfunction

endpackage

// File: rtl/ram_bist_master_if.sv
// ---------------------------------------------------------------------------
// ram_bist_master_if
// Port of the 8-bit synchronous RAM as seen by a bus initiator.
//   address  RAM address
//   data     RAM write data
//   w_r      1 = write, 0 = read
//   cs       chip select
//   ram_out  RAM read data, valid RD_LAT cycles after a sampled read
// Modports: master (the initiator) and slave (the RAM responder).
// ---------------------------------------------------------------------------
interface ram_bist_master_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic          w_r;
    logic          cs;
    logic [DW-1:0] ram_out;

    modport master (output address, output data, output w_r, output cs, input ram_out);
    modport slave  (input address, input data, input w_r, input cs, output ram_out);
endinterface

// File: rtl/ram_bist_master_rdpipe.sv
// ---------------------------------------------------------------------------
// ram_bist_master_rdpipe
// RD_LAT-stage shift register of {valid, addr, expected}. It carries each read
// command's expected word alongside the RAM's read latency. As a result, the
// stage output lines up with ram_out.
//   clk, rst     clock and synchronous active-high clear
//   in_valid     a read command is on the bus this cycle
//   in_addr      its address
//   in_exp       its expected data
//   out_*        oldest stage; aligned with valid ram_out
// ---------------------------------------------------------------------------
module ram_bist_master_rdpipe #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_exp,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_exp
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [AW-1:0]     addr_q [RD_LAT];
    logic [AW-1:0]     addr_d [RD_LAT];
    logic [DW-1:0]     exp_q  [RD_LAT];
    logic [DW-1:0]     exp_d  [RD_LAT];

    // Next-stage values: stage 0 takes the new command, the others shift.
    always_comb begin
        vld_d     = vld_q;
        addr_d    = addr_q;
        exp_d     = exp_q;
        vld_d[0]  = in_valid;
        addr_d[0] = in_addr;
        exp_d[0]  = in_exp;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
            exp_d[i]  = exp_q[i-1];
        end
    end

    // Pipe registers; reset discards every in-flight compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                addr_q[i] <= {AW{1'b0}};
                exp_q[i]  <= {DW{1'b0}};
            end
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            exp_q  <= exp_d;
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_addr  = addr_q[RD_LAT-1];
    assign out_exp   = exp_q[RD_LAT-1];

endmodule

// File: rtl/ram_bist_master.sv
// ---------------------------------------------------------------------------
// ram_bist_master
// RAM self-test initiator. On start, the block writes seed + k to address
// base + k for k = 0..len. After one turnaround cycle, it reads the same range
// back and compares every word. It then reports pass/fail, the mismatch count
// and the first failing address.
//   clk, rst        clock, synchronous active-high reset
//   start           begin a test (sampled only while idle)
//   base/len/seed   first address, word count minus one, pattern seed
//   busy            high from the cycle after start until DONE
//   done            one-cycle pulse at the end of a test
//   pass            no mismatches; held from done until the next start
//   err_cnt         mismatch count (AW+1 bits, so 2^AW fits)
//   first_err_addr  address of the first mismatch, 0 if none
//   bus             RAM port (master modport)
// All outputs are registered. Each *_d value is the value the output will
// show in the following cycle.
// ---------------------------------------------------------------------------
module ram_bist_master
    import ram_bist_master_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AW-1:0]          base,
    input  logic [AW-1:0]          len,
    input  logic [DW-1:0]          seed,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [AW:0]            err_cnt,
    output logic [AW-1:0]          first_err_addr,
    ram_bist_master_if.master      bus
);

    localparam logic [AW-1:0] K_ZERO     = {AW{1'b0}};
    localparam logic [AW-1:0] K_ONE      = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO   = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};
    localparam int            DRAIN_LAST = RD_LAT - 32'sd1;

    state_t        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] len_q, len_d;
    logic [DW-1:0] seed_q, seed_d;
    logic [7:0]    drain_q, drain_d;
    logic [AW-1:0] address_q, address_d;
    logic [DW-1:0] data_q, data_d;
    logic          w_r_q, w_r_d;
    logic          cs_q, cs_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [AW:0]   err_cnt_q, err_cnt_d;
    logic [AW-1:0] first_q, first_d;

    logic          push_valid_s;
    logic [DW-1:0] push_exp_s;
    logic          pipe_valid_s;
    logic [AW-1:0] pipe_addr_s;
    logic [DW-1:0] pipe_exp_s;

    // The read command currently on the bus enters the compare pipe.
    // Its address is already in address_q.
    assign push_valid_s = (state_q == ST_READ);
    assign push_exp_s   = DW'(pat(32'(seed_q), 32'(k_q)));

    ram_bist_master_rdpipe #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push_valid_s),
        .in_addr   (address_q),
        .in_exp    (push_exp_s),
        .out_valid (pipe_valid_s),
        .out_addr  (pipe_addr_s),
        .out_exp   (pipe_exp_s)
    );

    // Sequencer, bus command generation and read-back comparison.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        base_d    = base_q;
        len_d     = len_q;
        seed_d    = seed_q;
        drain_d   = drain_q;
        address_d = address_q;
        data_d    = data_q;
        w_r_d     = w_r_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        first_d   = first_q;

        // Only the first mismatch of a run records its address.
        if (pipe_valid_s && (bus.ram_out != pipe_exp_s)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
            if (err_cnt_q == CNT_ZERO) begin
                first_d = pipe_addr_s;
            end else begin
                first_d = first_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
            first_d   = first_q;
        end

        case (state_q)
            ST_IDLE: begin
                cs_d = 1'b0;
                if (start) begin
                    state_d   = ST_WRITE;
                    base_d    = base;
                    len_d     = len;
                    seed_d    = seed;
                    k_d       = K_ZERO;
                    err_cnt_d = CNT_ZERO;
                    first_d   = K_ZERO;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    cs_d      = 1'b1;
                    w_r_d     = 1'b1;
                    address_d = base;
                    data_d    = seed;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (k_q == len_q) begin
                    state_d = ST_TURN;
                    cs_d    = 1'b0;
                    w_r_d   = 1'b0;
                end else begin
                    k_d       = k_q + K_ONE;
                    address_d = base_q + k_d;
                    data_d    = DW'(pat(32'(seed_q), 32'(k_d)));
                end
            end
            ST_TURN: begin
                state_d   = ST_READ;
                k_d       = K_ZERO;
                cs_d      = 1'b1;
                w_r_d     = 1'b0;
                address_d = base_q;
            end
            ST_READ: begin
                if (k_q == len_q) begin
                    state_d = ST_DRAIN;
                    cs_d    = 1'b0;
                    drain_d = 8'd0;
                end else begin
                    k_d       = k_q + K_ONE;
                    address_d = base_q + k_d;
                end
            end
            ST_DRAIN: begin
                // The last read's compare happens in the final drain cycle.
                // pass therefore uses the updated count.
                if (drain_q == 8'(DRAIN_LAST)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == CNT_ZERO);
                end else begin
                    drain_d = drain_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= K_ZERO;
            base_q    <= K_ZERO;
            len_q     <= K_ZERO;
            seed_q    <= {DW{1'b0}};
            drain_q   <= 8'd0;
            address_q <= K_ZERO;
            data_q    <= {DW{1'b0}};
            w_r_q     <= 1'b0;
            cs_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= CNT_ZERO;
            first_q   <= K_ZERO;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            base_q    <= base_d;
            len_q     <= len_d;
            seed_q    <= seed_d;
            drain_q   <= drain_d;
            address_q <= address_d;
            data_q    <= data_d;
            w_r_q     <= w_r_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
        end
    end

    assign bus.address    = address_q;
    assign bus.data       = data_q;
    assign bus.w_r        = w_r_q;
    assign bus.cs         = cs_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_q;

endmodule
